// File: rtl/cache_arbiter_pkg.sv
// Shared types and constants for the round-robin L1-to-L2 cache arbiter.
package cache_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAccess  = 2'd1,
    StRespond = 2'd2
  } arb_state_e;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } arb_op_e;

  localparam int unsigned ArbModeRr    = 0;
  localparam int unsigned ArbModeFixed = 1;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational grant picker: first active request at or after the pointer, or the
// lowest-index active request when fixed priority is selected.
module rr_priority_picker #(
  parameter int unsigned NumPorts = 2,
  parameter int unsigned PtrW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic [NumPorts-1:0] req_i,
  input  logic [PtrW-1:0]     ptr_i,
  input  logic                mode_fixed_i,
  output logic [NumPorts-1:0] grant_o,
  output logic                valid_o
);

  logic [PtrW-1:0]       start;
  logic [2*NumPorts-1:0] req_dbl;
  logic [2*NumPorts-1:0] gnt_dbl;
  logic [NumPorts-1:0]   req_rot;
  logic [NumPorts-1:0]   gnt_rot;

  // Rotate so the start port sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    start   = mode_fixed_i ? '0 : ptr_i;
    req_dbl = {req_i, req_i} >> start;
    req_rot = req_dbl[NumPorts-1:0];
    gnt_rot = req_rot & (-req_rot);
    gnt_dbl = {gnt_rot, gnt_rot} << start;
    grant_o = gnt_dbl[2*NumPorts-1:NumPorts];
    valid_o = |req_i;
  end

endmodule

// File: rtl/cache_arbiter_rr.sv
// Arbitrates line read/write requests from several L1 ports onto one L2 command channel.
module cache_arbiter_rr
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LINE_W    = 256,
  parameter int unsigned ARB_MODE  = ArbModeRr
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_PORTS-1:0]               req_read,
  input  logic [NUM_PORTS-1:0]               req_write,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS-1:0][LINE_W-1:0]   req_wdata,
  output logic [LINE_W-1:0]                  req_rdata,
  output logic [NUM_PORTS-1:0]               req_resp,
  output logic                               l2_read,
  output logic                               l2_write,
  output logic [ADDR_W-1:0]                  l2_address,
  output logic [LINE_W-1:0]                  l2_wdata,
  input  logic [LINE_W-1:0]                  l2_rdata,
  input  logic                               l2_resp
);

  localparam int unsigned PtrW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic        ModeFixed = (ARB_MODE == ArbModeFixed);

  arb_state_e           state_q, state_d;
  arb_op_e              op_q, op_d;
  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LINE_W-1:0]    wdata_q, wdata_d;
  logic [LINE_W-1:0]    rdata_q, rdata_d;
  logic                 l2_read_q, l2_read_d;
  logic                 l2_write_q, l2_write_d;

  logic [NUM_PORTS-1:0] req_active;
  logic [NUM_PORTS-1:0] pick_grant;
  logic                 pick_valid;
  logic [ADDR_W-1:0]    sel_addr;
  logic [LINE_W-1:0]    sel_wdata;
  logic                 sel_write;
  logic [PtrW-1:0]      gnt_idx;
  logic [PtrW-1:0]      next_ptr;

  assign req_active = req_read | req_write;

  rr_priority_picker #(
    .NumPorts (NUM_PORTS),
    .PtrW     (PtrW)
  ) u_picker (
    .req_i        (req_active),
    .ptr_i        (rr_ptr_q),
    .mode_fixed_i (ModeFixed),
    .grant_o      (pick_grant),
    .valid_o      (pick_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (pick_grant[i]) begin
        sel_addr  = req_addr[i];
        sel_wdata = req_wdata[i];
      end
    end
  end

  // A port raising both read and write is served as a write.
  assign sel_write = |(req_write & pick_grant);

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (gnt_q[i]) gnt_idx = PtrW'(i);
    end
  end

  assign next_ptr = (gnt_idx == PtrW'(NUM_PORTS - 1)) ? '0 : gnt_idx + PtrW'(1);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    l2_read_d  = l2_read_q;
    l2_write_d = l2_write_q;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d    = StAccess;
          gnt_d      = pick_grant;
          addr_d     = sel_addr;
          wdata_d    = sel_wdata;
          op_d       = sel_write ? OpWrite : OpRead;
          l2_read_d  = !sel_write;
          l2_write_d = sel_write;
        end
      end
      StAccess: begin
        // The latched command runs to completion regardless of what the port does now.
        if (l2_resp) begin
          state_d    = StRespond;
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
          if (op_q == OpRead) rdata_d = l2_rdata;
        end
      end
      StRespond: begin
        state_d  = StIdle;
        rr_ptr_d = next_ptr;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= OpRead;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      l2_read_q  <= 1'b0;
      l2_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      l2_read_q  <= l2_read_d;
      l2_write_q <= l2_write_d;
    end
  end

  assign l2_read    = l2_read_q;
  assign l2_write   = l2_write_q;
  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;
  assign req_rdata  = rdata_q;
  assign req_resp   = (state_q == StRespond) ? gnt_q : '0;

endmodule

// File: tb/tb_cache_arbiter_rr.sv
// Directed plus randomized bench for cache_arbiter_rr with a transaction-level model.
module tb_cache_arbiter_rr;

  localparam int N = 4;

  logic clk;
  logic rst;

  // Round-robin instance
  logic [N-1:0]          req_read, req_write, req_resp;
  logic [N-1:0][31:0]    req_addr;
  logic [N-1:0][255:0]   req_wdata;
  logic [255:0]          req_rdata, l2_wdata, l2_rdata;
  logic                  l2_read, l2_write, l2_resp;
  logic [31:0]           l2_address;

  // Fixed-priority instance
  logic [N-1:0]          fp_req_read, fp_req_write, fp_req_resp;
  logic [N-1:0][31:0]    fp_req_addr;
  logic [N-1:0][255:0]   fp_req_wdata;
  logic [255:0]          fp_req_rdata, fp_l2_wdata;
  logic [255:0]          fp_l2_rdata = '0;
  logic                  fp_l2_read, fp_l2_write;
  logic                  fp_l2_resp = 1'b0;
  logic [31:0]           fp_l2_address;

  cache_arbiter_rr #(.NUM_PORTS(N), .ADDR_W(32), .LINE_W(256), .ARB_MODE(0)) u_dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rdata(req_rdata), .req_resp(req_resp), .l2_read(l2_read),
    .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata), .l2_rdata(l2_rdata),
    .l2_resp(l2_resp)
  );

  cache_arbiter_rr #(.NUM_PORTS(N), .ADDR_W(32), .LINE_W(256), .ARB_MODE(1)) u_dut_fp (
    .clk(clk), .rst(rst), .req_read(fp_req_read), .req_write(fp_req_write),
    .req_addr(fp_req_addr), .req_wdata(fp_req_wdata), .req_rdata(fp_req_rdata),
    .req_resp(fp_req_resp), .l2_read(fp_l2_read), .l2_write(fp_l2_write),
    .l2_address(fp_l2_address), .l2_wdata(fp_l2_wdata), .l2_rdata(fp_l2_rdata),
    .l2_resp(fp_l2_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return {8{a ^ 32'hC3A5_0F1E}};
  endfunction

  // L2 responder: answers in the l2_delay-th cycle of a held command.
  int           l2_delay = 1;
  int           l2_cnt = 0;
  bit           l2_auto = 1'b1;
  bit           l2_use_fixed = 1'b0;
  logic [255:0] l2_fixed = '0;
  logic         resp_auto = 1'b0;
  logic         resp_man = 1'b0;

  assign l2_resp = l2_auto ? resp_auto : resp_man;

  always @(posedge clk) begin
    #1;
    if ((l2_read || l2_write) && !resp_auto) begin
      l2_cnt++;
      if (l2_cnt >= l2_delay) begin
        resp_auto = 1'b1;
        l2_rdata  = l2_use_fixed ? l2_fixed : line_of(l2_address);
        l2_cnt    = 0;
      end
    end else begin
      resp_auto = 1'b0;
      l2_cnt    = 0;
      l2_rdata  = {8{$urandom}};
    end
  end

  always @(posedge clk) begin
    #1;
    if ((fp_l2_read || fp_l2_write) && !fp_l2_resp) begin
      fp_l2_resp  = 1'b1;
      fp_l2_rdata = line_of(fp_l2_address);
    end else begin
      fp_l2_resp = 1'b0;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]   w_r;
  int           w_cyc, w_rd, w_wr, w_both;
  logic [31:0]  w_addr;
  logic [255:0] w_data;

  task automatic wait_resp(output logic [3:0] r, output int cyc, output int rd_c,
                           output int wr_c, output int both_c, output logic [31:0] a_seen,
                           output logic [255:0] d_seen);
    r = '0; cyc = 0; rd_c = 0; wr_c = 0; both_c = 0; a_seen = '0; d_seen = '0;
    while (r == '0 && cyc < 40) begin
      step();
      cyc++;
      if (l2_read === 1'b1) rd_c++;
      if (l2_write === 1'b1) wr_c++;
      if (l2_read && l2_write) both_c++;
      if ((l2_read || l2_write) && (rd_c + wr_c == 1)) begin
        a_seen = l2_address;
        d_seen = l2_wdata;
      end
      r = req_resp;
    end
    chk("resp_seen", 256'(|r), 256'd1);
  endtask

  task automatic fp_wait(output logic [3:0] r);
    int cyc = 0;
    r = '0;
    while (r == '0 && cyc < 20) begin
      step();
      cyc++;
      r = fp_req_resp;
    end
    chk("fp_resp_seen", 256'(|r), 256'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Reference model state for the randomized phase
  bit [N-1:0]   pend, pr, pw;
  logic [31:0]  pa [N];
  logic [255:0] pd [N];
  int           mptr, g, d;
  bit           first;
  logic [255:0] last_rd;

  task automatic new_reqs();
    int op;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(0, 1) == 1) begin
        op = $urandom_range(0, 2);
        pend[i] = 1'b1;
        pr[i] = (op != 1);
        pw[i] = (op != 0);
        pa[i] = $urandom;
        pd[i] = {8{$urandom}};
      end
    end
    if (pend == '0) begin
      op = $urandom_range(0, N - 1);
      pend[op] = 1'b1; pr[op] = 1'b1; pw[op] = 1'b0; pa[op] = $urandom;
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_read[i]  = pend[i] & pr[i];
      req_write[i] = pend[i] & pw[i];
      req_addr[i]  = pa[i];
      req_wdata[i] = pd[i];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    fp_req_read = '0; fp_req_write = '0; fp_req_addr = '0; fp_req_wdata = '0;
    step();
    chk("rst_l2_read", 256'(l2_read), 256'd0);
    chk("rst_l2_write", 256'(l2_write), 256'd0);
    chk("rst_req_resp", 256'(req_resp), 256'd0);
    chk("rst_l2_address", 256'(l2_address), 256'd0);
    chk("rst_l2_wdata", l2_wdata, 256'd0);
    chk("rst_req_rdata", req_rdata, 256'd0);
    rst = 1'b0;
    step();

    // Single read with a 4-cycle L2 wait
    l2_use_fixed = 1'b1; l2_fixed = {32{8'hA5}}; l2_delay = 4;
    req_read[1] = 1'b1; req_addr[1] = 32'h0000_1040;
    wait_resp(w_r, w_cyc, w_rd, w_wr, w_both, w_addr, w_data);
    chk("single_resp", 256'(w_r), 256'h2);
    chk("single_rd_cycles", 256'(w_rd), 256'd4);
    chk("single_wr_cycles", 256'(w_wr), 256'd0);
    chk("single_latency", 256'(w_cyc), 256'd5);
    chk("single_addr", 256'(w_addr), 256'h1040);
    chk("single_rdata", req_rdata, {32{8'hA5}});
    req_read[1] = 1'b0;
    step();
    chk("single_pulse_width", 256'(req_resp), 256'd0);

    // Stray l2_resp while idle is ignored
    l2_auto = 1'b0; resp_man = 1'b1;
    step();
    step();
    chk("idle_l2resp_resp", 256'(req_resp), 256'd0);
    chk("idle_l2resp_read", 256'(l2_read), 256'd0);
    resp_man = 1'b0;
    step();
    chk("idle_l2resp_rdata", req_rdata, {32{8'hA5}});
    l2_auto = 1'b1; l2_use_fixed = 1'b0; l2_delay = 1;

    // Round-robin fairness with all ports reading continuously
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_addr[i] = 32'h3000 + 32'(i * 64);
      req_read[i] = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      wait_resp(w_r, w_cyc, w_rd, w_wr, w_both, w_addr, w_data);
      chk("rr_grant", 256'(w_r), 256'd1 << (k % N));
      chk("rr_spacing", 256'(w_cyc), (k == 0) ? 256'd2 : 256'd3);
      chk("rr_rdata", req_rdata, line_of(32'h3000 + 32'((k % N) * 64)));
    end
    req_read = '0;
    last_rd = line_of(32'h3000);
    step();

    // Read and write together are served as a write
    req_read[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h200;
    req_wdata[0] = {8{32'hDEAD_0200}};
    wait_resp(w_r, w_cyc, w_rd, w_wr, w_both, w_addr, w_data);
    chk("wp_resp", 256'(w_r), 256'h1);
    chk("wp_write_cycles", 256'(w_wr), 256'd1);
    chk("wp_read_cycles", 256'(w_rd), 256'd0);
    chk("wp_addr", 256'(w_addr), 256'h200);
    chk("wp_wdata", w_data, {8{32'hDEAD_0200}});
    chk("wp_rdata_held", req_rdata, last_rd);
    req_read = '0; req_write = '0;
    step();

    // Reset in the second ACCESS cycle abandons the transaction and clears rr_ptr
    req_read[2] = 1'b1; req_addr[2] = 32'h2200;
    wait_resp(w_r, w_cyc, w_rd, w_wr, w_both, w_addr, w_data);
    chk("rst_pre_resp", 256'(w_r), 256'h4);
    req_read = '0;
    step();
    l2_delay = 5;
    req_read[3] = 1'b1; req_addr[3] = 32'h3300;
    step();
    step();
    chk("rst_mid_access_read", 256'(l2_read), 256'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_l2_read", 256'(l2_read), 256'd0);
    chk("rst_mid_l2_address", 256'(l2_address), 256'd0);
    chk("rst_mid_req_rdata", req_rdata, 256'd0);
    req_read = '0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_mid_no_resp", 256'(req_resp), 256'd0);
    end
    rst = 1'b0; l2_delay = 1;
    step();
    chk("rst_after_no_resp", 256'(req_resp), 256'd0);
    req_read[1] = 1'b1; req_addr[1] = 32'h1100;
    req_read[3] = 1'b1; req_addr[3] = 32'h3300;
    wait_resp(w_r, w_cyc, w_rd, w_wr, w_both, w_addr, w_data);
    chk("rst_ptr_first", 256'(w_r), 256'h2);
    req_read[1] = 1'b0;
    wait_resp(w_r, w_cyc, w_rd, w_wr, w_both, w_addr, w_data);
    chk("rst_ptr_second", 256'(w_r), 256'h8);
    chk("rst_ptr_rdata", req_rdata, line_of(32'h3300));
    req_read = '0;
    step();

    // Requester drops its read during ACCESS
    l2_delay = 3;
    req_read[0] = 1'b1; req_addr[0] = 32'h600;
    step();
    req_read[0] = 1'b0;
    wait_resp(w_r, w_cyc, w_rd, w_wr, w_both, w_addr, w_data);
    chk("drop_resp", 256'(w_r), 256'h1);
    chk("drop_latency", 256'(w_cyc), 256'd3);
    chk("drop_rdata", req_rdata, line_of(32'h600));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("drop_single_pulse", 256'(req_resp), 256'd0);
    end

    // Fixed priority: port 0 keeps winning while it re-requests
    fp_req_read[0] = 1'b1; fp_req_addr[0] = 32'h4000;
    fp_req_read[2] = 1'b1; fp_req_addr[2] = 32'h4200;
    for (int k = 0; k < 4; k++) begin
      fp_wait(w_r);
      chk("fp_grant", 256'(w_r), (k < 3) ? 256'h1 : 256'h4);
      if (k == 2) fp_req_read[0] = 1'b0;
    end
    chk("fp_rdata", fp_req_rdata, line_of(32'h4200));
    fp_req_read = '0;

    // Randomized traffic against the transaction-level model
    l2_delay = 1;
    do_reset();
    pend = '0; pr = '0; pw = '0; mptr = 0; first = 1'b1; last_rd = '0;
    new_reqs();
    drive_reqs();
    d = $urandom_range(1, 4);
    l2_delay = d;
    for (int t = 0; t < 60; t++) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        int p;
        p = (mptr + k) % N;
        if (g < 0 && pend[p]) g = p;
      end
      wait_resp(w_r, w_cyc, w_rd, w_wr, w_both, w_addr, w_data);
      chk("rnd_grant", 256'(w_r), 256'd1 << g);
      chk("rnd_latency", 256'(w_cyc), first ? 256'(d + 1) : 256'(d + 2));
      chk("rnd_both_high", 256'(w_both), 256'd0);
      chk("rnd_addr", 256'(w_addr), 256'(pa[g]));
      if (pw[g]) begin
        chk("rnd_write_cycles", 256'(w_wr), 256'(d));
        chk("rnd_wdata", w_data, pd[g]);
      end else begin
        chk("rnd_read_cycles", 256'(w_rd), 256'(d));
        last_rd = line_of(pa[g]);
      end
      chk("rnd_rdata", req_rdata, last_rd);
      pend[g] = 1'b0;
      mptr = (g + 1) % N;
      first = 1'b0;
      new_reqs();
      drive_reqs();
      d = $urandom_range(1, 4);
      l2_delay = d;
    end
    req_read = '0; req_write = '0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_arbiter_rr.md
CACHE_ARBITER_RR -- requirements
Module: cache_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of L1 requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter LINE_W, default 256, cache line width.
REQ-004 SHALL have parameter ARB_MODE, default 0, 0 = round-robin, 1 = fixed priority with port 0 highest.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 req_read  input  NUM_PORTS  per-port line read request, held until that port's req_resp.
REQ-009 req_write  input  NUM_PORTS  per-port line write request, held until that port's req_resp.
REQ-010 req_addr  input  NUM_PORTS x ADDR_W  per-port line address.
REQ-011 req_wdata  input  NUM_PORTS x LINE_W  per-port write line.
REQ-012 req_rdata  output  LINE_W  read line, broadcast to all ports.
REQ-013 req_resp  output  NUM_PORTS  one-hot, one-cycle completion pulse.
REQ-014 l2_read / l2_write  output  1 each  L2 commands, never both high.
REQ-015 l2_address  output  ADDR_W; l2_wdata  output  LINE_W  registered command payload.
REQ-016 l2_rdata  input  LINE_W; l2_resp  input  1  L2 completion, valid for one cycle.

Function
REQ-017 SHALL implement the states IDLE, ACCESS and RESPOND.
REQ-018 IDLE: on any active port, SHALL choose a grant and load the address register from req_addr[g] and the data register from req_wdata[g], record op (write if req_write[g], else read), and go to ACCESS; otherwise SHALL stay in IDLE.
REQ-019 Grant selection in round-robin mode SHALL pick the first active port at or after rr_ptr, wrapping from NUM_PORTS-1 to 0.
REQ-020 Grant selection in fixed-priority mode SHALL pick the lowest-index active port.
REQ-021 When req_read and req_write are both high on one port, the port SHALL be served as a write.
REQ-022 ACCESS: SHALL hold l2_read or l2_write (per recorded op) high with registered l2_address and l2_wdata until l2_resp.
REQ-023 ACCESS: on l2_resp, SHALL capture l2_rdata (reads only) and go to RESPOND.
REQ-024 ACCESS: l2_read and l2_write SHALL drop in the cycle after l2_resp.
REQ-025 RESPOND: SHALL assert req_resp[g] for exactly one cycle and drive req_rdata from the captured line.
REQ-026 RESPOND: SHALL set rr_ptr = (g+1) mod NUM_PORTS and return to IDLE.
REQ-027 Minimum latency from a request seen in IDLE to req_resp SHALL be 3 cycles with l2_resp in the first ACCESS cycle; the arbiter adds 2 cycles beyond the L2 wait.
REQ-028 A request dropping or changing during ACCESS SHALL be ignored; the latched transaction completes and req_resp still pulses.
REQ-029 l2_resp in IDLE or RESPOND SHALL be ignored.
REQ-030 Requests arriving during ACCESS or RESPOND SHALL wait; no port SHALL wait more than NUM_PORTS grants in round-robin mode.
REQ-031 req_rdata SHALL hold the last captured line until the next read capture.

Reset
REQ-032 rst SHALL force IDLE, rr_ptr = 0, l2_read = l2_write = 0, req_resp = 0, and l2_address, l2_wdata and req_rdata = 0, asynchronously, including mid-ACCESS.
REQ-033 An in-flight L2 transaction SHALL be abandoned on reset, with no req_resp issued.

Structure
REQ-034 The state enum and ARB_MODE constants SHALL reside in cache_arbiter_pkg.
REQ-035 Grant selection SHALL be a combinational sub-module rr_priority_picker (inputs: request vector, pointer, mode; output: one-hot grant, valid).

Verification
REQ-036 Single read: NUM_PORTS=2, port1 reads 0x0000_1040, L2 responds after 4 cycles with 0xA5..A5 -> l2_read high 4 cycles, req_resp=2'b10 one cycle, req_rdata=0xA5..A5.
REQ-037 Round-robin fairness: NUM_PORTS=4, all ports read continuously, l2_resp 1 cycle later -> grant order 0,1,2,3,0, each req_resp 3 cycles apart.
REQ-038 Fixed priority: ARB_MODE=1, ports 0 and 2 request together -> port 0 served first, port 2 second; port 2 starves while port 0 re-requests.
REQ-039 Write precedence: port 0 asserts read and write on 0x200 -> l2_write=1, l2_read=0, l2_wdata=req_wdata[0].
REQ-040 Reset mid-ACCESS: rst asserted during the 2nd ACCESS cycle -> l2_read=0 in the same cycle, no req_resp, rr_ptr=0, and the next request from port 1 goes to port 1.
REQ-041 Request drop: port 0 drops req_read in ACCESS -> transaction completes and req_resp[0] still pulses once.
